sprite_layer_compositor: RTL and testbench

- Sits directly downstream of the sprite/ROM blocks.
- Takes NUM_SRC per-pixel sprite outputs: valid, layer and 24-bit RGB.
- Picks one winning colour per pixel, or the background colour when no sprite claims the pixel.
- Delays the VGA coordinates and syncs so they stay aligned with the ROM-latent sprite data. Also reports per-frame sprite overlap (collision) for game logic.

---
 rtl/gfx_pkg.sv | 40 ++++
 rtl/vga_sync_delay.sv | 62 ++++++
 rtl/sprite_layer_compositor.sv | 223 ++++++++++++++++++++++
 tb/tb_sprite_layer_compositor.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gfx_pkg
//  Description : Shared graphics definitions for the sprite datapath: field
//                widths, the per-source pixel record and a helper that
//                extracts one source from the packed sprite buses.
//  Revision    : 1.0 - initial release
// ============================================================================
package gfx_pkg;

    localparam int LAYER_W = 6;
    localparam int RGB_W   = 24;
    localparam int VGA_X_W = 10;
    localparam int VGA_Y_W = 9;
    // Widest supported source count; packed buses are zero-padded to this.
    localparam int MAX_SRC = 8;

    typedef struct packed {
        logic               val;
        logic [LAYER_W-1:0] layer;
        logic [RGB_W-1:0]   rgb;
    } pixel_t;

    // Pull source k out of the (padded) packed buses. Shifts are used instead
    // of indexed part-selects so the extraction stays width-exact.
    function automatic pixel_t unpack_src(
        input logic [MAX_SRC-1:0]         val_bus,
        input logic [MAX_SRC*LAYER_W-1:0] layer_bus,
        input logic [MAX_SRC*RGB_W-1:0]   rgb_bus,
        input int                         k
    );
        pixel_t p;
        p.val   = 1'(val_bus >> k);
        p.layer = LAYER_W'(layer_bus >> (k * LAYER_W));
        p.rgb   = RGB_W'(rgb_bus >> (k * RGB_W));
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_delay
//  Description : Fixed-depth shift register for the VGA coordinate, sync and
//                blank signals, so they stay aligned with the latent sprite
//                colour path. Reset loads the idle pattern (X = Y = 0,
//                HS = VS = 1, BLANK_N = 0) into every stage.
//  Ports       : clk, reset (async, active-high)
//                i_x/i_y/i_hs/i_vs/i_blank_n  - raw VGA timing
//                o_x/o_y/o_hs/o_vs/o_blank_n  - timing delayed by DEPTH
//                o_tap_origin/o_tap_blank_n   - stage DEPTH-1 view (one
//                                               cycle ahead of the outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_delay
    import gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VGA_X_W-1:0] i_x,
    input  logic [VGA_Y_W-1:0] i_y,
    input  logic               i_hs,
    input  logic               i_vs,
    input  logic               i_blank_n,
    output logic [VGA_X_W-1:0] o_x,
    output logic [VGA_Y_W-1:0] o_y,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_blank_n,
    output logic               o_tap_origin,
    output logic               o_tap_blank_n
);

    localparam int c_W = VGA_X_W + VGA_Y_W + 3;
    localparam logic [c_W-1:0] c_IDLE = {{VGA_X_W{1'b0}}, {VGA_Y_W{1'b0}}, 1'b1, 1'b1, 1'b0};

    logic [c_W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= c_IDLE;
            end
        end else begin
            r_pipe[0] <= {i_x, i_y, i_hs, i_vs, i_blank_n};
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {o_x, o_y, o_hs, o_vs, o_blank_n} = r_pipe[DEPTH-1];

    // The stage before the output describes the pixel whose sprite data is
    // currently in the compositor's first register stage.
    assign o_tap_origin  = (r_pipe[DEPTH-2][c_W-1:3] == '0);
    assign o_tap_blank_n = r_pipe[DEPTH-2][0];

endmodule
`default_nettype wire

// File: rtl/sprite_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_layer_compositor
//  Description : Chooses one colour per pixel from NUM_SRC sprite sources
//                (highest layer wins, lowest index on ties), falls back to
//                BG_RGB, blanks outside the active area, and re-aligns the
//                VGA timing to the two-cycle colour pipeline. Optionally
//                flags sprite overlap per frame.
//  Ports       : clk, reset (async, active-high), enable
//                iVal/iLayer/iRGB          - packed per-source sprite data
//                iVGA_X/iVGA_Y/iHS/iVS/iBLANK_N - raw VGA timing
//                oR/oG/oB                  - composited colour
//                oVGA_X/oVGA_Y/oHS/oVS/oBLANK_N - timing aligned to colour
//                oHitIdx/oHitVal           - winning source / hit flag
//                oCollision                - overlap seen in previous frame
//  Macro       : COMPOSITOR_COLLISION_EN enables the collision latch; when
//                undefined oCollision is constant 0.
//  Note        : LAYER_W must equal gfx_pkg::LAYER_W (pixel_t is built on it).
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_layer_compositor #(
    parameter int          NUM_SRC = 4,
    parameter int          LAYER_W = gfx_pkg::LAYER_W,
    parameter int          SRC_LAT = 2,
    parameter logic [23:0] BG_RGB  = 24'h000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_SRC-1:0]         iVal,
    input  logic [NUM_SRC*LAYER_W-1:0] iLayer,
    input  logic [NUM_SRC*24-1:0]      iRGB,
    input  logic [9:0]                 iVGA_X,
    input  logic [8:0]                 iVGA_Y,
    input  logic                       iHS,
    input  logic                       iVS,
    input  logic                       iBLANK_N,
    output logic [7:0]                 oR,
    output logic [7:0]                 oG,
    output logic [7:0]                 oB,
    output logic                       oHS,
    output logic                       oVS,
    output logic                       oBLANK_N,
    output logic [9:0]                 oVGA_X,
    output logic [8:0]                 oVGA_Y,
    output logic [2:0]                 oHitIdx,
    output logic                       oHitVal,
    output logic                       oCollision
);

    import gfx_pkg::*;

    // ------------------------------------------------------------------
    // Stage 1: register sprite inputs (valid already qualified by enable)
    // ------------------------------------------------------------------
    logic [MAX_SRC-1:0]                   w_val_pad;
    logic [MAX_SRC*gfx_pkg::LAYER_W-1:0]  w_layer_pad;
    logic [MAX_SRC*RGB_W-1:0]             w_rgb_pad;

    always_comb begin
        w_val_pad                       = '0;
        w_layer_pad                     = '0;
        w_rgb_pad                       = '0;
        w_val_pad[NUM_SRC-1:0]          = iVal & {NUM_SRC{enable}};
        w_layer_pad[NUM_SRC*LAYER_W-1:0] = iLayer;
        w_rgb_pad[NUM_SRC*RGB_W-1:0]    = iRGB;
    end

    pixel_t r_src [NUM_SRC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                r_src[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                r_src[k] <= unpack_src(w_val_pad, w_layer_pad, w_rgb_pad, k);
            end
        end
    end

    // ------------------------------------------------------------------
    // VGA timing delay; tap signals belong to the pixel in stage 1
    // ------------------------------------------------------------------
    logic w_tap_origin;
    logic w_tap_blank_n;

    vga_sync_delay #(
        .DEPTH (SRC_LAT + 2)
    ) u_sync_delay (
        .clk           (clk),
        .reset         (reset),
        .i_x           (iVGA_X),
        .i_y           (iVGA_Y),
        .i_hs          (iHS),
        .i_vs          (iVS),
        .i_blank_n     (iBLANK_N),
        .o_x           (oVGA_X),
        .o_y           (oVGA_Y),
        .o_hs          (oHS),
        .o_vs          (oVS),
        .o_blank_n     (oBLANK_N),
        .o_tap_origin  (w_tap_origin),
        .o_tap_blank_n (w_tap_blank_n)
    );

    // ------------------------------------------------------------------
    // Stage 2: winner select. Strict '>' keeps the earlier (lower) index
    // on equal layers.
    // ------------------------------------------------------------------
    logic               w_win_hit;
    logic [2:0]         w_win_idx;
    logic [LAYER_W-1:0] w_win_layer;
    logic [RGB_W-1:0]   w_win_rgb;

    always_comb begin
        w_win_hit   = 1'b0;
        w_win_idx   = 3'd0;
        w_win_layer = '0;
        w_win_rgb   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_src[k].val && (!w_win_hit || (r_src[k].layer > w_win_layer))) begin
                w_win_hit   = 1'b1;
                w_win_idx   = 3'(k);
                w_win_layer = r_src[k].layer;
                w_win_rgb   = r_src[k].rgb;
            end
        end
    end

    logic [RGB_W-1:0] r_rgb;
    logic [2:0]       r_idx;
    logic             r_hit;

    // Blanking is folded in here using the tap, which lands in the output
    // stage on the same edge as this colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
            r_idx <= 3'd0;
            r_hit <= 1'b0;
        end else begin
            r_idx <= w_win_idx;
            r_hit <= w_win_hit;
            if (!w_tap_blank_n) begin
                r_rgb <= '0;
            end else if (w_win_hit) begin
                r_rgb <= w_win_rgb;
            end else begin
                r_rgb <= BG_RGB;
            end
        end
    end

    assign oR      = r_rgb[23:16];
    assign oG      = r_rgb[15:8];
    assign oB      = r_rgb[7:0];
    assign oHitIdx = r_idx;
    assign oHitVal = r_hit;

    // ------------------------------------------------------------------
    // Collision: pending accumulates overlaps within a frame; at the first
    // cycle of the origin pixel it is transferred to oCollision. The first
    // boundary after reset only arms the latch, so a partial frame never
    // reports.
    // ------------------------------------------------------------------
`ifdef COMPOSITOR_COLLISION_EN
    generate
        if (NUM_SRC > 1) begin : g_collision
            logic [3:0] w_vcount;
            logic       w_overlap;
            logic       w_frame_start;
            logic       r_origin_prev;
            logic       r_pending;
            logic       r_armed;
            logic       r_collision;

            always_comb begin
                w_vcount = 4'd0;
                for (int k = 0; k < NUM_SRC; k++) begin
                    w_vcount = w_vcount + {3'b000, r_src[k].val};
                end
            end

            assign w_overlap     = (w_vcount >= 4'd2) && w_tap_blank_n;
            assign w_frame_start = w_tap_origin && !r_origin_prev;

            // r_origin_prev resets high: the idle delay-line contents read as
            // the origin and must not look like a new frame.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_origin_prev <= 1'b1;
                    r_pending     <= 1'b0;
                    r_armed       <= 1'b0;
                    r_collision   <= 1'b0;
                end else begin
                    r_origin_prev <= w_tap_origin;
                    if (w_frame_start) begin
                        r_collision <= r_armed & r_pending;
                        r_armed     <= 1'b1;
                        r_pending   <= w_overlap;
                    end else if (w_overlap) begin
                        r_pending   <= 1'b1;
                    end
                end
            end

            assign oCollision = r_collision;
        end else begin : g_no_collision
            logic w_unused_tap_origin;
            assign w_unused_tap_origin = w_tap_origin;
            assign oCollision          = 1'b0;
        end
    endgenerate
`else
    logic w_unused_tap_origin;
    assign w_unused_tap_origin = w_tap_origin;
    assign oCollision          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_compositor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_layer_compositor
//  Description : Self-checking bench for sprite_layer_compositor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_layer_compositor;

    localparam int          NS      = 4;
    localparam int          LW      = 6;
    localparam int          SRC_LAT = 2;
    localparam int          DLY     = SRC_LAT + 2;
    localparam logic [23:0] BG      = 24'h202020;
    localparam int          MAXH    = 4096;
`ifdef COMPOSITOR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b1;
    logic [NS-1:0]     iVal = '0;
    logic [NS*LW-1:0]  iLayer = '0;
    logic [NS*24-1:0]  iRGB = '0;
    logic [9:0]        iVGA_X = '0;
    logic [8:0]        iVGA_Y = '0;
    logic              iHS = 1'b1;
    logic              iVS = 1'b1;
    logic              iBLANK_N = 1'b0;
    logic [7:0]        oR, oG, oB;
    logic              oHS, oVS, oBLANK_N;
    logic [9:0]        oVGA_X;
    logic [8:0]        oVGA_Y;
    logic [2:0]        oHitIdx;
    logic              oHitVal;
    logic              oCollision;

    int n_vec = 0;
    int n_mis = 0;
    int n     = 0;

    // Stimulus history, indexed by clock edge since reset release.
    logic                 h_en  [MAXH];
    logic [NS-1:0]        h_val [MAXH];
    logic [NS-1:0][LW-1:0] h_lay [MAXH];
    logic [NS-1:0][23:0]  h_rgb [MAXH];
    logic [9:0]           h_x   [MAXH];
    logic [8:0]           h_y   [MAXH];
    logic                 h_hs  [MAXH];
    logic                 h_vs  [MAXH];
    logic                 h_bl  [MAXH];

    sprite_layer_compositor #(
        .NUM_SRC (NS),
        .LAYER_W (LW),
        .SRC_LAT (SRC_LAT),
        .BG_RGB  (BG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .iVal       (iVal),
        .iLayer     (iLayer),
        .iRGB       (iRGB),
        .iVGA_X     (iVGA_X),
        .iVGA_Y     (iVGA_Y),
        .iHS        (iHS),
        .iVS        (iVS),
        .iBLANK_N   (iBLANK_N),
        .oR         (oR),
        .oG         (oG),
        .oB         (oB),
        .oHS        (oHS),
        .oVS        (oVS),
        .oBLANK_N   (oBLANK_N),
        .oVGA_X     (oVGA_X),
        .oVGA_Y     (oVGA_Y),
        .oHitIdx    (oHitIdx),
        .oHitVal    (oHitVal),
        .oCollision (oCollision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Winner for the sprite sample taken at edge s: find the top layer among
    // valid sources, then the first source holding it.
    task automatic ref_win(input int s, output logic hit, output logic [2:0] idx,
                           output logic [23:0] rgb);
        int best;
        hit  = 1'b0;
        idx  = 3'd0;
        rgb  = BG;
        best = -1;
        if (s < 0) return;
        for (int k = 0; k < NS; k++)
            if (h_en[s] && h_val[s][k] && int'(h_lay[s][k]) > best) best = int'(h_lay[s][k]);
        if (best < 0) return;
        for (int k = 0; k < NS; k++) begin
            if (h_en[s] && h_val[s][k] && int'(h_lay[s][k]) == best) begin
                hit = 1'b1;
                idx = 3'(k);
                rgb = h_rgb[s][k];
                break;
            end
        end
    endtask

    // Frame-level collision: frames begin where the coordinate newly becomes
    // (0,0); a frame's verdict is visible during the following frame, and the
    // first frame boundary after reset never reports.
    function automatic logic exp_coll(input int c);
        logic latched = 1'b0;
        logic acc     = 1'b0;
        int   nb      = 0;
        bit   org, orgp;
        if (!COLL_EN) return 1'b0;
        for (int j = 0; j <= c - DLY + 1; j++) begin
            org  = (h_x[j] == 0) && (h_y[j] == 0);
            orgp = (j == 0) ? 1'b1 : ((h_x[j-1] == 0) && (h_y[j-1] == 0));
            if (org && !orgp) begin
                latched = (nb > 0) && acc;
                acc     = 1'b0;
                nb++;
            end
            if (h_bl[j] && $countones(h_val[j+SRC_LAT] & {NS{h_en[j+SRC_LAT]}}) >= 2) acc = 1'b1;
        end
        return latched;
    endfunction

    task automatic compare(input int c);
        int          j;
        logic        hit;
        logic [2:0]  idx;
        logic [23:0] rgb;
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic        ehs, evs, ebl;
        j = c - DLY + 1;
        if (j < 0) begin
            ex = '0; ey = '0; ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
        end else begin
            ex = h_x[j]; ey = h_y[j]; ehs = h_hs[j]; evs = h_vs[j]; ebl = h_bl[j];
        end
        ref_win(c - 1, hit, idx, rgb);
        if (!ebl) rgb = 24'h0;
        chk("vga_x",   32'(oVGA_X),   32'(ex));
        chk("vga_y",   32'(oVGA_Y),   32'(ey));
        chk("hs",      32'(oHS),      32'(ehs));
        chk("vs",      32'(oVS),      32'(evs));
        chk("blank_n", 32'(oBLANK_N), 32'(ebl));
        chk("rgb",     32'({oR, oG, oB}), 32'(rgb));
        chk("hit_idx", 32'(oHitIdx),  32'(idx));
        chk("hit_val", 32'(oHitVal),  32'(hit));
        chk("collision", 32'(oCollision), 32'(exp_coll(c)));
    endtask

    task automatic tick(input bit do_chk);
        if (n >= MAXH) begin
            $display("FAIL history_overflow: got %0d expected below %0d", n, MAXH);
            $fatal(1, "history overflow");
        end
        h_en[n] = enable; h_val[n] = iVal; h_lay[n] = iLayer; h_rgb[n] = iRGB;
        h_x[n] = iVGA_X; h_y[n] = iVGA_Y; h_hs[n] = iHS; h_vs[n] = iVS; h_bl[n] = iBLANK_N;
        @(posedge clk);
        #1;
        if (do_chk) compare(n);
        n++;
    endtask

    // Miniature 10x4 frame: columns 8..9 blanked, HS low at column 8,
    // VS low on the last row.
    task automatic set_coord(input int x, input int y);
        iVGA_X   = 10'(x);
        iVGA_Y   = 9'(y);
        iHS      = (x != 8);
        iVS      = (y != 3);
        iBLANK_N = (x < 8);
    endtask

    typedef struct {
        string               name;
        logic                en;
        logic [NS-1:0]       val;
        logic                bl;
        logic [NS-1:0][LW-1:0] lay;
        logic [NS-1:0][23:0] rgb;
        logic [23:0]         exp_rgb;
        logic [2:0]          exp_idx;
        logic                exp_hit;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"single",     1'b1, 4'b0001, 1'b1, {6'd0, 6'd0, 6'd0, 6'd3},
                    {24'h0, 24'h0, 24'h0, 24'hFF8000}, 24'hFF8000, 3'd0, 1'b1};
        vecs[1] = '{"priority",   1'b1, 4'b0110, 1'b1, {6'd0, 6'd9, 6'd5, 6'd0},
                    {24'h0, 24'h0000FF, 24'h00FF00, 24'h0}, 24'h0000FF, 3'd2, 1'b1};
        vecs[2] = '{"tie",        1'b1, 4'b0110, 1'b1, {6'd0, 6'd9, 6'd9, 6'd0},
                    {24'h0, 24'h0000FF, 24'h00FF00, 24'h0}, 24'h00FF00, 3'd1, 1'b1};
        vecs[3] = '{"background", 1'b1, 4'b0000, 1'b1, {6'd1, 6'd2, 6'd3, 6'd4},
                    {24'h1, 24'h2, 24'h3, 24'h4}, BG, 3'd0, 1'b0};
        vecs[4] = '{"blanked_bg", 1'b1, 4'b0000, 1'b0, {6'd1, 6'd2, 6'd3, 6'd4},
                    {24'h1, 24'h2, 24'h3, 24'h4}, 24'h000000, 3'd0, 1'b0};
        vecs[5] = '{"enable_low", 1'b0, 4'b1111, 1'b1, {6'd1, 6'd2, 6'd3, 6'd4},
                    {24'h1, 24'h2, 24'h3, 24'h4}, BG, 3'd0, 1'b0};
        vecs[6] = '{"unsigned",   1'b1, 4'b1001, 1'b1, {6'd63, 6'd0, 6'd0, 6'd62},
                    {24'hABCDEF, 24'h0, 24'h0, 24'h111111}, 24'hABCDEF, 3'd3, 1'b1};
        vecs[7] = '{"all_tie",    1'b1, 4'b1111, 1'b1, {6'd7, 6'd7, 6'd7, 6'd7},
                    {24'h444444, 24'h333333, 24'h222222, 24'h111111}, 24'h111111, 3'd0, 1'b1};
        vecs[8] = '{"blanked_hit", 1'b1, 4'b0100, 1'b0, {6'd0, 6'd1, 6'd0, 6'd0},
                    {24'h0, 24'h123456, 24'h0, 24'h0}, 24'h000000, 3'd2, 1'b1};
        vecs[9] = '{"src3_only",  1'b1, 4'b1000, 1'b1, {6'd0, 6'd0, 6'd0, 6'd0},
                    {24'hC0FFEE, 24'h0, 24'h0, 24'h0}, 24'hC0FFEE, 3'd3, 1'b1};

        // ---------------- reset state ----------------
        #1 reset = 1'b1;
        #1;
        chk("rst_rgb",       32'({oR, oG, oB}), 32'h0);
        chk("rst_hit",       32'({oHitVal, oHitIdx}), 32'h0);
        chk("rst_collision", 32'(oCollision), 32'h0);
        chk("rst_syncs",     32'({oHS, oVS, oBLANK_N}), 32'b110);
        chk("rst_xy",        32'({oVGA_X, oVGA_Y}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;

        // ---------------- table vectors ----------------
        iVGA_X = 10'd50; iVGA_Y = 9'd5; iHS = 1'b1; iVS = 1'b1;
        for (int v = 0; v < 10; v++) begin
            enable = vecs[v].en; iVal = vecs[v].val; iBLANK_N = vecs[v].bl;
            iLayer = vecs[v].lay; iRGB = vecs[v].rgb;
            repeat (DLY) tick(1'b1);
            chk({"tbl_rgb_", vecs[v].name}, 32'({oR, oG, oB}), 32'(vecs[v].exp_rgb));
            chk({"tbl_idx_", vecs[v].name}, 32'(oHitIdx), 32'(vecs[v].exp_idx));
            chk({"tbl_hit_", vecs[v].name}, 32'(oHitVal), 32'(vecs[v].exp_hit));
        end

        // ---------------- alignment: X=100 and HS fall ----------------
        enable = 1'b1; iVal = '0; iBLANK_N = 1'b1; iVGA_Y = 9'd5;
        for (int t = 0; t < 6; t++) begin
            iVGA_X = 10'(100 + t);
            iHS    = (t == 0);
            tick(1'b1);
            if (t == DLY - 2) chk("align_x_early", 32'(oVGA_X == 10'd100), 32'd0);
            if (t == DLY - 1) begin
                chk("align_x",  32'(oVGA_X), 32'd100);
                chk("align_hs_high", 32'(oHS), 32'd1);
            end
            if (t == DLY) begin
                chk("align_x_next", 32'(oVGA_X), 32'd101);
                chk("align_hs_fall", 32'(oHS), 32'd0);
            end
        end

        // ---------------- randomized frames ----------------
        for (int f = 0; f < 6; f++) begin
            for (int y = 0; y < 4; y++) begin
                for (int x = 0; x < 10; x++) begin
                    set_coord(x, y);
                    enable = ($urandom_range(0, 9) != 0);
                    for (int k = 0; k < NS; k++) begin
                        iVal[k] = ($urandom_range(0, 2) == 0);
                        iLayer[k*LW +: LW] = 6'($urandom_range(0, 7));
                        iRGB[k*24 +: 24]   = 24'($urandom);
                    end
                    tick(1'b1);
                end
            end
        end

        // ---------------- directed collision frames ----------------
        enable = 1'b1; iLayer = '0; iRGB = {24'h0000AA, 24'h0, 24'h0, 24'hAA0000};
        for (int f = 0; f < 4; f++) begin
            for (int y = 0; y < 4; y++) begin
                for (int x = 0; x < 10; x++) begin
                    set_coord(x, y);
                    iVal = (f == 1 && x == 5 && y == 1) ? 4'b1001 : 4'b0001;
                    tick(1'b1);
                    if (y == 2 && x == 0) begin
                        if (f == 1) chk("coll_frame_n",  32'(oCollision), 32'd0);
                        if (f == 2) chk("coll_frame_n1", 32'(oCollision), 32'(COLL_EN));
                        if (f == 3) chk("coll_frame_n2", 32'(oCollision), 32'd0);
                    end
                end
            end
        end

        // ---------------- asynchronous reset mid-line ----------------
        iVal = 4'b0010; iRGB = {24'h0, 24'h0, 24'h00FF00, 24'h0};
        iVGA_X = 10'd3; iVGA_Y = 9'd1; iBLANK_N = 1'b1; iHS = 1'b1; iVS = 1'b1;
        repeat (DLY + 1) tick(1'b1);
        chk("pre_reset_rgb", 32'({oR, oG, oB}), 32'h00FF00);
        #2 reset = 1'b1;
        #1;
        chk("arst_rgb",   32'({oR, oG, oB}), 32'h0);
        chk("arst_hit",   32'({oHitVal, oHitIdx}), 32'h0);
        chk("arst_syncs", 32'({oHS, oVS, oBLANK_N}), 32'b110);
        chk("arst_xy",    32'({oVGA_X, oVGA_Y}), 32'h0);
        chk("arst_coll",  32'(oCollision), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        iVal = '0; iVGA_X = 10'd20; iVGA_Y = 9'd2;
        for (int t = 0; t < DLY; t++) begin
            tick(1'b1);
            if (t == 1) begin
                chk("post_rst_hit",  32'(oHitVal), 32'd0);
                chk("post_rst_coll", 32'(oCollision), 32'd0);
            end
        end
        chk("post_rst_bg", 32'({oR, oG, oB}), 32'(BG));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
